// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl: branch prediction and resolution controller for the RV32 pipe.
//
// Purpose
//   * IF: predicts direction for if_pc from a direct-mapped table of 2-bit
//     saturating counters (bit 1 of the counter is the prediction).
//   * EX: drives BrUn to the comparator, decodes funct3 with BrEq/BrLT into
//     the resolved direction, trains the table and the performance counters.
//   * On a mispredict, holds flush/redirect_valid high for FLUSH_CYCLES
//     cycles with the corrected fetch PC on redirect_pc.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_pc, pred_taken   fetch-side lookup (combinational)
//   ex_valid            EX holds a valid instruction; there is no ready/stall
//                       back-pressure: an EX branch is consumed on the edge
//                       where ex_valid & ex_is_branch are high and the
//                       controller is IDLE, and is silently dropped while a
//                       flush is in progress (the pipe is being killed anyway)
//   ex_is_branch, ex_funct3, ex_pc, ex_target, ex_pred_taken   EX branch
//   br_un, br_eq, br_lt comparator interface
//   ex_taken            resolved direction, 0 when nothing resolves
//   flush, redirect_valid, redirect_pc   mispredict recovery
//   illegal_br          one-cycle registered pulse for funct3 010/011
//   branch_cnt, mispred_cnt              performance counters (wrap)
// -----------------------------------------------------------------------------
module branch_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        br_un,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        ex_taken,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        illegal_br,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] flush_left;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  logic legal;
  logic dir;
  logic resolve;
  logic mispredict;
  logic illegal_hit;

  // Only the index bits of if_pc are looked at.
  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Reads the pre-update table, so a same-cycle update of this index is
  // only visible from the next cycle on.
  assign pred_taken = bht[if_idx][1];

  // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed ones.
  assign br_un = ex_funct3[1];

  always_comb begin
    legal = 1'b1;
    dir   = 1'b0;
    case (ex_funct3)
      3'b000:          dir = br_eq;
      3'b001:          dir = ~br_eq;
      3'b100, 3'b110:  dir = br_lt;
      3'b101, 3'b111:  dir = ~br_lt;
      default:         legal = 1'b0;
    endcase
  end

  assign resolve     = ex_valid & ex_is_branch & legal & (state == IDLE);
  assign illegal_hit = ex_valid & ex_is_branch & ~legal & (state == IDLE);
  assign ex_taken    = resolve & dir;
  assign mispredict  = resolve & (dir != ex_pred_taken);

  // FSM: state register plus flush length counter and redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_left  <= '0;
      redirect_pc <= '0;
    end else begin
      state <= state_next;
      if (mispredict) begin
        flush_left  <= CNT_W'(FLUSH_CYCLES);
        redirect_pc <= dir ? ex_target : ex_pc + 32'd4;
      end else if (state == FLUSH) begin
        flush_left <= flush_left - CNT_W'(1);
      end
    end
  end

  // FSM: next state. The exit cycle (flush_left == 1) is still FLUSH, so a
  // branch presented in it is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mispredict) state_next = FLUSH;
      FLUSH:   if (flush_left == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state only.
  always_comb begin
    flush          = (state == FLUSH);
    redirect_valid = (state == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_br  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      illegal_br <= illegal_hit;
      if (resolve)    branch_cnt  <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Direction table, reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      if (dir && bht[ex_idx] != 2'b11)       bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!dir && bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

endmodule
